// File: rtl/phys_free_list.sv
// phys_free_list: ring-buffer free list of physical registers with speculative
// and committed heads, so a flush restores every speculative allocation in one cycle.
module phys_free_list #(
    parameter int NUM_ARCH_REGS = 35,
    parameter int NUM_PHYS_REGS = 64,
    parameter NAME = "FREELIST"
) (
    input  logic                                 CLK,
    input  logic                                 RESET,
    input  logic                                 Alloc_req,
    output logic                                 Alloc_valid,
    output logic [$clog2(NUM_PHYS_REGS)-1:0]     Alloc_preg,
    input  logic                                 Retire_valid,
    input  logic [$clog2(NUM_PHYS_REGS)-1:0]     Retire_old_preg,
    input  logic                                 Flush,
    output logic [$clog2(NUM_PHYS_REGS):0]       Free_count,
    output logic                                 Error
);
    localparam int LP = $clog2(NUM_PHYS_REGS);
    localparam int CAP = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam logic [LP:0] CAP_C = (LP+1)'(CAP);

    logic [LP-1:0] ring_q [NUM_PHYS_REGS];
    logic [LP-1:0] ring_d [NUM_PHYS_REGS];
    logic [LP-1:0] spec_head_q, spec_head_d, commit_head_q, commit_head_d, tail_q, tail_d;
    logic [LP:0]   spec_cnt_q, spec_cnt_d, commit_cnt_q, commit_cnt_d;
    logic          error_q, error_d;
    logic          alloc, ret, no_outstanding;

    function automatic logic [LP-1:0] nxt(input logic [LP-1:0] p);
        return (p == LP'(NUM_PHYS_REGS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign Alloc_valid = (spec_cnt_q != '0);
    assign Alloc_preg  = ring_q[spec_head_q];
    assign Free_count  = spec_cnt_q;
    assign Error       = error_q;

    always_comb begin
        alloc          = Alloc_req && Alloc_valid && !Flush;
        ret            = Retire_valid;
        no_outstanding = (commit_head_q == spec_head_q) && (spec_cnt_q == commit_cnt_q);
        ring_d         = ring_q;
        if (ret) ring_d[tail_q] = Retire_old_preg;
        tail_d         = ret ? nxt(tail_q) : tail_q;
        commit_head_d  = ret ? nxt(commit_head_q) : commit_head_q;
        // A retire advances tail and commit_head together, so the committed free count never moves.
        commit_cnt_d   = commit_cnt_q;
        spec_head_d    = Flush ? commit_head_d : (alloc ? nxt(spec_head_q) : spec_head_q);
        spec_cnt_d     = Flush ? commit_cnt_d
                               : spec_cnt_q + (LP+1)'(ret) - (LP+1)'(alloc);
        error_d        = error_q || (ret && (no_outstanding || spec_cnt_q == CAP_C));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_PHYS_REGS; i++)
                ring_q[i] <= (i < CAP) ? LP'(NUM_ARCH_REGS + i) : '0;
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= LP'(CAP);
            spec_cnt_q    <= CAP_C;
            commit_cnt_q  <= CAP_C;
            error_q       <= 1'b0;
        end else begin
            ring_q        <= ring_d;
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            spec_cnt_q    <= spec_cnt_d;
            commit_cnt_q  <= commit_cnt_d;
            error_q       <= error_d;
        end
    end
endmodule

// File: tb/tb_phys_free_list.sv
// tb_phys_free_list: directed stimulus with a scoreboard queue checked by a separate monitor.
module tb_phys_free_list;
    logic       CLK = 1'b0;
    logic       RESET, Alloc_req, Retire_valid, Flush;
    logic [5:0] Retire_old_preg, Alloc_preg;
    logic       Alloc_valid, Error;
    logic [6:0] Free_count;

    phys_free_list dut (
        .CLK(CLK), .RESET(RESET), .Alloc_req(Alloc_req), .Alloc_valid(Alloc_valid),
        .Alloc_preg(Alloc_preg), .Retire_valid(Retire_valid), .Retire_old_preg(Retire_old_preg),
        .Flush(Flush), .Free_count(Free_count), .Error(Error)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       full;
        logic       v;
        logic [5:0] p;
        logic [6:0] c;
        logic       e;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   model[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("error", int'(Error), int'(x.e));
            if (x.full) begin
                chk("alloc_valid", int'(Alloc_valid), int'(x.v));
                chk("free_count", int'(Free_count), int'(x.c));
                if (x.v) chk("alloc_preg", int'(Alloc_preg), int'(x.p));
            end
        end
    end

    task automatic step(input bit rst, input bit req, input bit rv, input int old, input bit fl,
                        input bit full, input bit v, input int p, input int c, input bit e);
        exp_t x;
        RESET = rst;
        Alloc_req = req;
        Retire_valid = rv;
        Retire_old_preg = 6'(old);
        Flush = fl;
        @(posedge CLK);
        x.full = full; x.v = v; x.p = 6'(p); x.c = 7'(c); x.e = e;
        sb.push_back(x);
        #1;
    endtask

    initial begin
        RESET = 1'b1; Alloc_req = 1'b0; Retire_valid = 1'b0; Flush = 1'b0; Retire_old_preg = '0;
        step(1, 0, 0, 0, 0, 1, 1, 35, 29, 0);
        step(1, 0, 0, 0, 0, 1, 1, 35, 29, 0);
        for (int k = 0; k < 29; k++) step(0, 1, 0, 0, 0, 1, k < 28, 36 + k, 28 - k, 0);
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 7, 0, 1, 1, 7, 1, 0);
        step(0, 0, 0, 0, 1, 1, 1, 36, 29, 0);

        step(1, 0, 0, 0, 0, 1, 1, 35, 29, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 0, 1, 1, 36 + k, 28 - k, 0);
        step(0, 0, 1, 3, 0, 1, 1, 40, 25, 0);
        step(0, 0, 1, 4, 0, 1, 1, 40, 26, 0);
        step(0, 0, 0, 0, 1, 1, 1, 37, 29, 0);
        for (int j = 0; j < 27; j++) step(0, 1, 0, 0, 0, 1, 1, (j < 26) ? 38 + j : 3, 28 - j, 0);
        step(0, 1, 0, 0, 0, 1, 1, 4, 1, 0);
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);

        step(1, 0, 0, 0, 0, 1, 1, 35, 29, 0);
        step(0, 1, 0, 0, 0, 1, 1, 36, 28, 0);
        for (int k = 36; k < 64; k++) model.push_back(k);
        for (int i = 0; i < 200; i++) begin
            int old;
            old = (i * 7 + 5) % 64;
            void'(model.pop_front());
            model.push_back(old);
            step(0, 1, 1, old, 0, 1, 1, model[0], 28, 0);
        end
        model.push_back(9);
        step(0, 1, 1, 9, 1, 1, 1, model[0], 29, 0);
        void'(model.pop_front());
        step(0, 1, 0, 0, 0, 1, 1, model[0], 28, 0);

        step(1, 0, 0, 0, 0, 1, 1, 35, 29, 0);
        step(0, 0, 1, 5, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1, 1, 35, 29, 0);
        step(0, 0, 0, 0, 0, 1, 1, 35, 29, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge CLK);
            #1;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
